// File: rtl/next_code_gen.sv
// Canonical Huffman "next code" generator.
// Scans INDEX_COUNT entries of a length memory, builds a per-length histogram,
// then derives the first canonical code for every length 1..15 and flags an
// oversubscribed length set.
module next_code_gen #(
    parameter int INDEX_BIT   = 9,
    parameter int LEN_BIT     = 4,
    parameter int COUNT_BIT   = 9,
    parameter int LEN_ADDRESS = 9,
    parameter int INDEX_COUNT = 19
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [INDEX_BIT+LEN_BIT-1:0] i_len_data,
    output logic [LEN_ADDRESS-1:0]       o_len_address,
    output logic                         len_ena,
    output logic                         len_wea,
    output logic [2*COUNT_BIT-1:0]       next_0,
    output logic [2*COUNT_BIT-1:0]       next_1,
    output logic [2*COUNT_BIT-1:0]       next_2,
    output logic [2*COUNT_BIT-1:0]       next_3,
    output logic [2*COUNT_BIT-1:0]       next_4,
    output logic [2*COUNT_BIT-1:0]       next_5,
    output logic [2*COUNT_BIT-1:0]       next_6,
    output logic [2*COUNT_BIT-1:0]       next_7,
    output logic [2*COUNT_BIT-1:0]       next_8,
    output logic [2*COUNT_BIT-1:0]       next_9,
    output logic [2*COUNT_BIT-1:0]       next_10,
    output logic [2*COUNT_BIT-1:0]       next_11,
    output logic [2*COUNT_BIT-1:0]       next_12,
    output logic [2*COUNT_BIT-1:0]       next_13,
    output logic [2*COUNT_BIT-1:0]       next_14,
    output logic [2*COUNT_BIT-1:0]       next_15,
    output logic                         sig_end,
    output logic                         o_err
);

    localparam int CODE_W = 2 * COUNT_BIT;
    // Scan cycle counter must reach INDEX_COUNT+1 (the last data sample).
    localparam int CNT_W  = $clog2(INDEX_COUNT + 2) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, CODE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              bits_q, bits_d;
    logic [CODE_W-1:0]       code_q, code_d;
    logic [LEN_ADDRESS-1:0]  addr_q, addr_d;
    logic                    ena_q, ena_d;
    logic                    end_q, end_d;
    logic                    err_q, err_d;
    logic [COUNT_BIT-1:0]    bl_count_q [16];
    logic [COUNT_BIT-1:0]    bl_count_d [16];
    logic [CODE_W-1:0]       next_q [16];
    logic [CODE_W-1:0]       next_d [16];

    logic [CNT_W-1:0]        scan_cyc;
    logic [LEN_BIT-1:0]      len_val;
    logic [COUNT_BIT-1:0]    add_val;
    logic [CODE_W-1:0]       code_new;
    logic [32:0]             err_sum;
    logic [32:0]             err_limit;

    // The symbol index half of the read word carries nothing this block needs.
    logic unused_index;
    assign unused_index = ^i_len_data[INDEX_BIT+LEN_BIT-1:LEN_BIT];

    // Next-state and datapath: scan sequencing, histogram update, code steps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        code_d     = code_q;
        addr_d     = addr_q;
        ena_d      = ena_q;
        end_d      = end_q;
        err_d      = err_q;
        bl_count_d = bl_count_q;
        next_d     = next_q;
        scan_cyc   = cnt_q + CNT_W'(1);
        len_val    = i_len_data[LEN_BIT-1:0];
        add_val    = '0;
        code_new   = '0;
        err_sum    = '0;
        err_limit  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int k = 0; k < 16; k++) begin
                        bl_count_d[k] = '0;
                        next_d[k]     = '0;
                    end
                    err_d   = 1'b0;
                    end_d   = 1'b0;
                    code_d  = '0;
                    cnt_d   = '0;
                    bits_d  = 4'd1;
                    addr_d  = '0;
                    ena_d   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // scan_cyc is the number of edges elapsed since the start edge.
                cnt_d = scan_cyc;
                if (scan_cyc <= CNT_W'(INDEX_COUNT - 1)) begin
                    addr_d = LEN_ADDRESS'(scan_cyc);
                    ena_d  = 1'b1;
                end else begin
                    ena_d  = 1'b0;
                end
                // Read data trails its address by two edges.
                if (scan_cyc >= CNT_W'(2)) begin
                    for (int k = 1; k < 16; k++) begin
                        if (k < (1 << LEN_BIT) && len_val == LEN_BIT'(k)) begin
                            bl_count_d[k] = bl_count_q[k] + COUNT_BIT'(1);
                        end
                    end
                end
                if (scan_cyc == CNT_W'(INDEX_COUNT + 1)) begin
                    bits_d  = 4'd1;
                    state_d = CODE;
                end
            end
            CODE: begin
                // Length 0 never counts toward code space.
                add_val   = (bits_q == 4'd1) ? '0 : bl_count_q[bits_q - 4'd1];
                code_new  = (code_q + CODE_W'(add_val)) << 1;
                code_d    = code_new;
                next_d[bits_q] = code_new;
                err_sum   = 33'(code_new) + 33'(bl_count_q[bits_q]);
                err_limit = 33'(1) << bits_q;
                if (err_sum > err_limit) begin
                    err_d = 1'b1;
                end
                if (bits_q == 4'd15) begin
                    end_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    bits_d = bits_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any computation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= 4'd1;
            code_q  <= '0;
            addr_q  <= '0;
            ena_q   <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                bl_count_q[k] <= '0;
                next_q[k]     <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            ena_q   <= ena_d;
            end_q   <= end_d;
            err_q   <= err_d;
            for (int k = 0; k < 16; k++) begin
                bl_count_q[k] <= bl_count_d[k];
                next_q[k]     <= next_d[k];
            end
        end
    end

    assign o_len_address = addr_q;
    assign len_ena       = ena_q;
    assign len_wea       = 1'b0;
    assign sig_end       = end_q;
    assign o_err         = err_q;

    assign next_0  = next_q[0];
    assign next_1  = next_q[1];
    assign next_2  = next_q[2];
    assign next_3  = next_q[3];
    assign next_4  = next_q[4];
    assign next_5  = next_q[5];
    assign next_6  = next_q[6];
    assign next_7  = next_q[7];
    assign next_8  = next_q[8];
    assign next_9  = next_q[9];
    assign next_10 = next_q[10];
    assign next_11 = next_q[11];
    assign next_12 = next_q[12];
    assign next_13 = next_q[13];
    assign next_14 = next_q[14];
    assign next_15 = next_q[15];

endmodule

// File: tb/tb_next_code_gen.sv
// Testbench for next_code_gen: length memory model, reference model computed
// from the canonical-code rules, directed and randomized jobs.
module tb_next_code_gen;

    localparam int INDEX_BIT   = 9;
    localparam int LEN_BIT     = 4;
    localparam int COUNT_BIT   = 9;
    localparam int LEN_ADDRESS = 9;
    localparam int INDEX_COUNT = 19;
    localparam int DW          = INDEX_BIT + LEN_BIT;
    localparam int CW          = 2 * COUNT_BIT;
    localparam int MEM_DEPTH   = 1 << LEN_ADDRESS;
    localparam int END_CYC     = 35;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [DW-1:0]          i_len_data = '0;
    logic [LEN_ADDRESS-1:0] o_len_address;
    logic                   len_ena;
    logic                   len_wea;
    logic                   sig_end;
    logic                   o_err;
    logic [CW-1:0]          next_w [16];

    logic [DW-1:0]          mem [MEM_DEPTH];
    longint                 exp_next [16];
    int                     exp_err;
    int                     num_checks = 0;
    int                     num_errors = 0;

    next_code_gen #(
        .INDEX_BIT(INDEX_BIT), .LEN_BIT(LEN_BIT), .COUNT_BIT(COUNT_BIT),
        .LEN_ADDRESS(LEN_ADDRESS), .INDEX_COUNT(INDEX_COUNT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .i_len_data(i_len_data),
        .o_len_address(o_len_address), .len_ena(len_ena), .len_wea(len_wea),
        .next_0(next_w[0]),   .next_1(next_w[1]),   .next_2(next_w[2]),
        .next_3(next_w[3]),   .next_4(next_w[4]),   .next_5(next_w[5]),
        .next_6(next_w[6]),   .next_7(next_w[7]),   .next_8(next_w[8]),
        .next_9(next_w[9]),   .next_10(next_w[10]), .next_11(next_w[11]),
        .next_12(next_w[12]), .next_13(next_w[13]), .next_14(next_w[14]),
        .next_15(next_w[15]),
        .sig_end(sig_end), .o_err(o_err)
    );

    always #5 clock = ~clock;

    // Length memory with one registered read stage behind the address register.
    always @(posedge clock) begin
        if (len_ena) i_len_data <= mem[o_len_address];
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        num_checks++;
        if (got != exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entries past the scanned window hold nonzero lengths so overreads show up.
    task automatic fill_tail();
        for (int a = INDEX_COUNT; a < MEM_DEPTH; a++)
            mem[a] = {INDEX_BIT'($urandom), LEN_BIT'($urandom_range(1, 15))};
    endtask

    task automatic set_len(input int a, input int len);
        mem[a] = {INDEX_BIT'($urandom), LEN_BIT'(len)};
    endtask

    task automatic load_req032();
        int lens [8] = '{3, 3, 3, 3, 3, 2, 4, 4};
        for (int a = 0; a < INDEX_COUNT; a++) set_len(a, (a < 8) ? lens[a] : 0);
        fill_tail();
    endtask

    task automatic load_random(input int mode);
        int len;
        for (int a = 0; a < INDEX_COUNT; a++) begin
            case (mode)
                0:       len = $urandom_range(0, 15);
                1:       len = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 15);
                default: len = $urandom_range(0, 3);
            endcase
            set_len(a, len);
        end
        fill_tail();
    endtask

    // Canonical code rules applied with ordinary integer arithmetic.
    task automatic ref_model();
        longint cnt [16];
        longint code;
        for (int k = 0; k < 16; k++) cnt[k] = 0;
        for (int a = 0; a < INDEX_COUNT; a++) begin
            int len = int'(mem[a][LEN_BIT-1:0]);
            if (len != 0) cnt[len] = (cnt[len] + 1) % (64'd1 << COUNT_BIT);
        end
        code = 0;
        exp_err = 0;
        exp_next[0] = 0;
        for (int b = 1; b < 16; b++) begin
            code = ((code + ((b == 1) ? 0 : cnt[b-1])) * 2) % (64'd1 << CW);
            exp_next[b] = code;
            if (code + cnt[b] > (64'd1 << b)) exp_err = 1;
        end
    endtask

    task automatic check_results(input string tag);
        check_val({tag, "_o_err"}, longint'(o_err), longint'(exp_err));
        for (int k = 0; k < 16; k++)
            check_val($sformatf("%s_next%0d", tag, k), longint'(next_w[k]), exp_next[k]);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_addr"}, longint'(o_len_address), 0);
        check_val({tag, "_len_ena"}, longint'(len_ena), 0);
        check_val({tag, "_len_wea"}, longint'(len_wea), 0);
        check_val({tag, "_sig_end"}, longint'(sig_end), 0);
        check_val({tag, "_o_err"}, longint'(o_err), 0);
        for (int k = 0; k < 16; k++)
            check_val($sformatf("%s_next%0d", tag, k), longint'(next_w[k]), 0);
    endtask

    // One job: start at edge E0, follow the scan, time sig_end, check results.
    // extra_start > 0 pulses start again so that it is sampled at E0+extra_start.
    task automatic run_job(input string tag, input int extra_start);
        int rise = -1;
        ref_model();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 0; c < 60 && rise < 0; c++) begin
            @(negedge clock);
            start = (extra_start > 0 && c + 1 == extra_start) ? 1'b1 : 1'b0;
            if (c <= INDEX_COUNT - 1) begin
                check_val($sformatf("%s_addr_c%0d", tag, c), longint'(o_len_address), c);
                check_val($sformatf("%s_ena_c%0d", tag, c), longint'(len_ena), 1);
            end else begin
                check_val($sformatf("%s_ena_c%0d", tag, c), longint'(len_ena), 0);
            end
            check_val($sformatf("%s_wea_c%0d", tag, c), longint'(len_wea), 0);
            if (c == 0) begin
                check_val({tag, "_err_clr"}, longint'(o_err), 0);
                for (int k = 0; k < 16; k++)
                    check_val($sformatf("%s_clr_next%0d", tag, k), longint'(next_w[k]), 0);
            end
            if (sig_end) rise = c;
        end
        start = 1'b0;
        check_val({tag, "_sig_end_cycle"}, rise, END_CYC);
        check_results({tag, "_at_end"});
        repeat (3) @(negedge clock);
        check_val({tag, "_sig_end_hold"}, longint'(sig_end), 1);
        check_results({tag, "_hold"});
        $display("job %s: sig_end at E0+%0d o_err=%0d next_2=%0d next_15=%0d",
                 tag, rise, o_err, next_w[2], next_w[15]);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_val("idle_len_ena", longint'(len_ena), 0);
        check_val("idle_sig_end", longint'(sig_end), 0);

        // Known small code set, independent of the reference model.
        load_req032();
        run_job("req032", 0);
        check_val("req032_const_next3", longint'(next_w[3]), 2);
        check_val("req032_const_next4", longint'(next_w[4]), 14);
        for (int k = 5; k < 16; k++)
            check_val($sformatf("req032_const_next%0d", k), longint'(next_w[k]), 64'd1 << k);

        for (int a = 0; a < INDEX_COUNT; a++) set_len(a, 0);
        fill_tail();
        run_job("req033_zero", 0);

        for (int a = 0; a < INDEX_COUNT; a++) set_len(a, (a < 3) ? 1 : 0);
        fill_tail();
        run_job("req034_oversub", 0);
        check_val("req034_const_next2", longint'(next_w[2]), 6);
        check_val("req034_const_err", longint'(o_err), 1);

        // Reset in the middle of a scan aborts the job.
        load_req032();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals("abort_async");
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_val("abort_no_resume_end", longint'(sig_end), 0);
        check_val("abort_no_resume_ena", longint'(len_ena), 0);
        run_job("req036_after_abort", 0);

        // Start during SCAN is ignored; start in DONE recomputes.
        load_req032();
        run_job("req037_ignored", 5);
        run_job("req037_restart", 0);

        for (int j = 0; j < 24; j++) begin
            load_random(j % 3);
            run_job($sformatf("rand%0d_m%0d", j, j % 3), (j % 4 == 1) ? $urandom_range(1, 30) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
